tl_error_responder: RTL and testbench



---
 rtl/tl_error_responder_if.sv | 31 +++
 rtl/tl_error_responder.sv | 191 +++++++++++++++++++
 tb/tb_tl_error_responder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_error_responder_if.sv
// TileLink-UL A/D channel bundle for the error responder.
// The initiator drives through the master modport; the responder sits on slave.
interface tl_error_responder_if #(
  parameter int unsigned SOURCE_W = 4
);
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [31:0]         a_address;

  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [2:0]          d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                d_denied;
  logic                d_corrupt;
  logic [31:0]         d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data
  );
endinterface

// File: rtl/tl_error_responder.sv
// TileLink-UL error responder: accepts any request, answers every beat as denied.
// Define TL_ERROR_RESPONDER_POISON_EN to return 32'hDEADBEEF on data beats instead of zero.
module tl_error_responder #(
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  tl_error_responder_if.slave  tl,
  output logic                 busy,
  output logic [CNT_W-1:0]     err_count
);

  localparam int unsigned OP_W    = 3;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BEAT_W  = 4;

  localparam logic [OP_W-1:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [OP_W-1:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [OP_W-1:0] D_HINT_ACK        = 3'd2;

`ifdef TL_ERROR_RESPONDER_POISON_EN
  localparam logic [DATA_W-1:0] RESP_DATA = 32'hDEADBEEF;
`else
  localparam logic [DATA_W-1:0] RESP_DATA = 32'h0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   cnt_q, cnt_d;
  logic                a_ready_q, a_ready_d;
  logic                d_valid_q, d_valid_d;
  logic [OP_W-1:0]     d_opcode_q, d_opcode_d;
  logic [SIZE_W-1:0]   d_size_q, d_size_d;
  logic [SOURCE_W-1:0] d_source_q, d_source_d;
  logic                d_denied_q, d_denied_d;
  logic                d_corrupt_q, d_corrupt_d;
  logic [DATA_W-1:0]   d_data_q, d_data_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    err_q, err_d;

  logic                a_hs;
  logic                d_hs;
  logic [BEAT_W-1:0]   last_beat;
  logic                is_data_d;
  logic                addr_unused;

  // Address plays no part in an error response.
  assign addr_unused = ^tl.a_address;

  assign a_hs = tl.a_valid & a_ready_q;
  assign d_hs = d_valid_q & tl.d_ready;

  // Beats minus one for a 32-bit bus, clamped at 16 beats.
  always_comb begin
    last_beat = '0;
    unique case (tl.a_size)
      3'd0, 3'd1, 3'd2: last_beat = 4'd0;
      3'd3:             last_beat = 4'd1;
      3'd4:             last_beat = 4'd3;
      3'd5:             last_beat = 4'd7;
      default:          last_beat = 4'd15;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (a_hs) begin
          d_size_d   = tl.a_size;
          d_source_d = tl.a_source;
          unique case (tl.a_opcode)
            3'd0, 3'd1: begin
              d_opcode_d = D_ACCESS_ACK;
              cnt_d      = last_beat;
              state_d    = (last_beat != 4'd0) ? ABSORB : RESP;
            end
            3'd2, 3'd3, 3'd4: begin
              d_opcode_d = D_ACCESS_ACK_DATA;
              cnt_d      = last_beat;
              state_d    = RESP;
            end
            3'd5: begin
              d_opcode_d = D_HINT_ACK;
              cnt_d      = 4'd0;
              state_d    = RESP;
            end
            default: begin
              d_opcode_d = D_ACCESS_ACK;
              cnt_d      = 4'd0;
              state_d    = RESP;
            end
          endcase
        end
      end

      ABSORB: begin
        // Counter holds the Put beats still to arrive; reaches zero for the response.
        if (a_hs) begin
          cnt_d = cnt_q - 4'(1);
          if (cnt_q == 4'd1) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        if (d_hs) begin
          if (cnt_q == 4'd0) begin
            state_d = IDLE;
            if (err_q != {CNT_W{1'b1}}) begin
              err_d = err_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q - 4'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    is_data_d   = (d_opcode_d == D_ACCESS_ACK_DATA);
    a_ready_d   = (state_d != RESP);
    d_valid_d   = (state_d == RESP);
    busy_d      = (state_d != IDLE);
    d_denied_d  = d_valid_d;
    d_corrupt_d = d_valid_d & is_data_d;
    d_data_d    = (d_valid_d & is_data_d) ? RESP_DATA : '0;
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_ready_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_data_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_ready_q   <= a_ready_d;
      d_valid_q   <= d_valid_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
      d_data_q    <= d_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign tl.a_ready   = a_ready_q;
  assign tl.d_valid   = d_valid_q;
  assign tl.d_opcode  = d_opcode_q;
  assign tl.d_size    = d_size_q;
  assign tl.d_source  = d_source_q;
  assign tl.d_denied  = d_denied_q;
  assign tl.d_corrupt = d_corrupt_q;
  assign tl.d_data    = d_data_q;
  assign busy         = busy_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_tl_error_responder.sv
// Self-checking bench for tl_error_responder: randomized requests against a
// transaction-level model of beat counts, response fields and error counting.
module tb_tl_error_responder;

  localparam int unsigned SOURCE_W = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int          LIMIT    = 200;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

`ifdef TL_ERROR_RESPONDER_POISON_EN
  localparam logic [31:0] POISON = 32'hDEADBEEF;
`else
  localparam logic [31:0] POISON = 32'h0;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;

  tl_error_responder_if #(.SOURCE_W(SOURCE_W)) tl();

  tl_error_responder #(.SOURCE_W(SOURCE_W), .CNT_W(CNT_W)) dut (
    .clock     (clk),
    .reset_n   (rst_n),
    .tl        (tl),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic int model_beats(input int size);
    if (size <= 2) return 1;
    if (size > 6)  return 16;
    return 1 << (size - 2);
  endfunction

  // One full transaction: A beats in, D beats out, every cycle checked.
  // mode 0: d_ready high; 1: d_ready toggles; 2: random a_valid gaps and d_ready.
  task automatic run_txn(input int op, input int size, input int src, input int mode, input bit keep_a);
    int          a_beats, d_beats, sent, got, cyc;
    bit          hs, data, tog;
    logic [2:0]  exp_op;
    logic [31:0] exp_data;
    a_beats  = (op <= 1) ? model_beats(size) : 1;
    data     = (op >= 2 && op <= 4);
    d_beats  = data ? model_beats(size) : 1;
    exp_op   = data ? 3'd1 : ((op == 5) ? 3'd2 : 3'd0);
    exp_data = data ? POISON : 32'h0;
    tl.a_opcode  = 3'(op);
    tl.a_size    = 3'(size);
    tl.a_source  = SOURCE_W'(src);
    tl.a_address = $urandom;
    sent = 0; cyc = 0;
    while (sent < a_beats) begin
      tl.a_valid = (mode == 2 && sent > 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      tl.d_ready = 1'($urandom_range(0, 1));
      if (sent > 0) begin
        n_tests++;
        if (tl.d_valid !== 1'b0 || tl.a_ready !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL absorb op=%0d beat=%0d: d_valid=%b a_ready=%b busy=%b, required 0 1 1",
                   op, sent, tl.d_valid, tl.a_ready, busy);
        end
      end
      hs = tl.a_valid && (tl.a_ready === 1'b1);
      @(negedge clk);
      cyc++;
      if (hs) sent++;
      if (cyc > LIMIT) begin
        n_fail++;
        $display("FAIL a_timeout op=%0d: accepted %0d beats, required %0d", op, sent, a_beats);
        break;
      end
    end
    tl.a_valid = keep_a;

    n_tests++;
    if (tl.d_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL d_latency op=%0d: d_valid=%b one cycle after last A beat, required 1", op, tl.d_valid);
    end

    got = 0; cyc = 0; tog = 1'b0;
    while (got < d_beats) begin
      case (mode)
        0:       tl.d_ready = 1'b1;
        1:       begin tl.d_ready = tog; tog = ~tog; end
        default: tl.d_ready = 1'($urandom_range(0, 1));
      endcase
      n_tests++;
      if (tl.d_valid !== 1'b1 || tl.a_ready !== 1'b0 || busy !== 1'b1 ||
          tl.d_opcode !== exp_op || tl.d_size !== 3'(size) || tl.d_source !== SOURCE_W'(src) ||
          tl.d_denied !== 1'b1 || tl.d_corrupt !== data || tl.d_data !== exp_data) begin
        n_fail++;
        $display("FAIL d_beat op=%0d beat=%0d: v=%b ar=%b busy=%b opc=%0d size=%0d src=%0d den=%b cor=%b data=%h, required v=1 ar=0 busy=1 opc=%0d size=%0d src=%0d den=1 cor=%b data=%h",
                 op, got, tl.d_valid, tl.a_ready, busy, tl.d_opcode, tl.d_size, tl.d_source,
                 tl.d_denied, tl.d_corrupt, tl.d_data, exp_op, size, src, data, exp_data);
      end
      hs = tl.d_ready;
      @(negedge clk);
      cyc++;
      if (hs) got++;
      if (cyc > LIMIT) begin
        n_fail++;
        $display("FAIL d_timeout op=%0d: saw %0d beats, required %0d", op, got, d_beats);
        break;
      end
    end
    tl.d_ready = 1'b0;

    exp_err = (exp_err < CNT_MAX) ? exp_err + 1 : CNT_MAX;
    n_tests++;
    if (tl.d_valid !== 1'b0 || tl.a_ready !== 1'b1 || busy !== 1'b0 || err_count !== CNT_W'(exp_err)) begin
      n_fail++;
      $display("FAIL done op=%0d: d_valid=%b a_ready=%b busy=%b err_count=%0d, required 0 1 0 %0d",
               op, tl.d_valid, tl.a_ready, busy, err_count, exp_err);
    end
  endtask

  task automatic test_reset();
    tl.a_valid = 1'b0; tl.a_opcode = '0; tl.a_size = '0; tl.a_source = '0;
    tl.a_address = '0; tl.d_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (tl.a_ready !== 1'b0 || tl.d_valid !== 1'b0 || busy !== 1'b0 || err_count !== '0 ||
        tl.d_opcode !== '0 || tl.d_size !== '0 || tl.d_source !== '0 ||
        tl.d_denied !== 1'b0 || tl.d_corrupt !== 1'b0 || tl.d_data !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: ar=%b v=%b busy=%b err=%0d opc=%0d den=%b cor=%b data=%h, required all zero",
               tl.a_ready, tl.d_valid, busy, err_count, tl.d_opcode, tl.d_denied, tl.d_corrupt, tl.d_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (tl.a_ready !== 1'b1 || busy !== 1'b0 || tl.d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: a_ready=%b busy=%b d_valid=%b, required 1 0 0", tl.a_ready, busy, tl.d_valid);
    end
    exp_err = 0;
  endtask

  task automatic test_get_single();
    run_txn(4, 2, 3, 0, 1'b0);
    n_tests++;
    if (err_count !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL get_single_err: err_count=%0d, required 1", err_count);
    end
  endtask

  task automatic test_get_burst();
    run_txn(4, 6, 9, 1, 1'b0);
    run_txn(2, 7, 5, 2, 1'b0);
  endtask

  task automatic test_put_burst();
    run_txn(0, 4, 6, 0, 1'b0);
    run_txn(1, 5, 12, 2, 1'b0);
  endtask

  task automatic test_hint_op7();
    run_txn(5, 3, 1, 0, 1'b0);
    run_txn(7, 6, 14, 1, 1'b0);
    run_txn(6, 5, 2, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn(4, 3, 7, 0, 1'b1);
    run_txn(0, 0, 8, 0, 1'b1);
    run_txn(5, 2, 15, 0, 1'b1);
    run_txn(3, 4, 4, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    tl.a_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int  cyc;
    bit  beat_seen;
    tl.a_opcode = 3'd4; tl.a_size = 3'd6; tl.a_source = SOURCE_W'(10);
    tl.a_valid = 1'b1;
    cyc = 0;
    while (tl.a_ready !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk); cyc++;
    end
    @(negedge clk);
    tl.a_valid = 1'b0;
    tl.d_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (tl.d_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: d_valid=%b busy=%b at fifth beat, required 1 1", tl.d_valid, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (tl.d_valid !== 1'b0 || tl.a_ready !== 1'b0 || busy !== 1'b0 || err_count !== '0 ||
        tl.d_opcode !== '0 || tl.d_size !== '0 || tl.d_source !== '0 ||
        tl.d_denied !== 1'b0 || tl.d_corrupt !== 1'b0 || tl.d_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: v=%b ar=%b busy=%b err=%0d opc=%0d den=%b cor=%b data=%h, required all zero",
               tl.d_valid, tl.a_ready, busy, err_count, tl.d_opcode, tl.d_denied, tl.d_corrupt, tl.d_data);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_err = 0;
    beat_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tl.d_valid !== 1'b0) beat_seen = 1'b1;
    end
    n_tests++;
    if (beat_seen || err_count !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_abandon: beat_seen=%b err_count=%0d busy=%b, required 0 0 0", beat_seen, err_count, busy);
    end
    tl.d_ready = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      run_txn(0, 0, i % 16, 0, 1'b0);
    end
    n_tests++;
    if (err_count !== {CNT_W{1'b1}}) begin
      n_fail++;
      $display("FAIL saturation: err_count=%0d, required %0d", err_count, CNT_MAX);
    end
  endtask

  initial begin
    test_reset();
    test_get_single();
    test_get_burst();
    test_put_burst();
    test_hint_op7();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
